// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
//
// Shared definitions for the register-bank write arbiter:
//   arb_state_e      - arbitration FSM state encoding (ARB, WRITE)
//   clog2()          - ceiling log2, used for derived index widths
//   *_RESET          - reset values for the round-robin pointer and the
//                      write staging registers
// ---------------------------------------------------------------------------
package reg_arb_pkg;

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      WRITE = 1'b1
   } arb_state_e;

   // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   localparam int unsigned PTR_RESET        = 0;
   localparam int unsigned STAGE_IDX_RESET  = 0;
   localparam int unsigned STAGE_ADDR_RESET = 0;
   localparam int unsigned STAGE_DATA_RESET = 0;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. Returns the first set bit of req found
// scanning upward from ptr and wrapping modulo NUM_REQ.
//
// Ports:
//   req    in   NUM_REQ  request vector
//   ptr    in   PTR_W    highest-priority position
//   grant  out  NUM_REQ  one-hot winner (all zero when req == 0)
//   idx    out  PTR_W    binary index of the winner (0 when req == 0)
// ---------------------------------------------------------------------------
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned PTR_W = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   idx
);

   logic [NUM_REQ-1:0]   mask;
   logic [2*NUM_REQ-1:0] dbl;
   logic                 found;

   // Lower half holds only requests at or above ptr; upper half holds all of
   // them, so a plain lowest-bit-first scan of dbl gives the wrapped order.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         mask[i] = (PTR_W'(i) >= ptr);
      end
      dbl = {req, req & mask};
   end

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned j = 0; j < 2 * NUM_REQ; j++) begin
         if (!found && dbl[j]) begin
            found                = 1'b1;
            idx                  = PTR_W'(j % NUM_REQ);
            grant[j % NUM_REQ]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_arbiter
//
// Round-robin write arbiter in front of a bank of NUM_REGS x DATA_W flops.
// Each two-cycle slot: ARB picks a winner and stages its addr/data while
// pulsing ack; WRITE commits the staged write and advances the pointer past
// the winner. Bank contents are exposed in parallel on q.
//
// Ports:
//   clk    in   1                 clock, rising edge
//   reset  in   1                 synchronous, active-high
//   req    in   NUM_REQ           per-requester write request (level)
//   addr   in   NUM_REQ*ADDR_W    packed register index per requester
//   wdata  in   NUM_REQ*DATA_W    packed write data per requester
//   ack    out  NUM_REQ           one-hot, one-cycle grant pulse (registered)
//   busy   out  1                 high while in WRITE
//   q      out  NUM_REGS*DATA_W   packed bank contents
// ---------------------------------------------------------------------------
module reg_bank_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned DATA_W   = 8,
   localparam int unsigned ADDR_W  = clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*ADDR_W-1:0]    addr,
   input  logic [NUM_REQ*DATA_W-1:0]    wdata,
   output logic [NUM_REQ-1:0]           ack,
   output logic                         busy,
   output logic [NUM_REGS*DATA_W-1:0]   q
);

   localparam int unsigned PTR_W = clog2(NUM_REQ);

   arb_state_e          state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    win_q, win_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                bank_we;

   logic [DATA_W-1:0]   bank_q [NUM_REGS];

   logic [NUM_REQ-1:0]  pick_grant;
   logic [PTR_W-1:0]    pick_idx;
   logic [ADDR_W-1:0]   pick_addr;
   logic [DATA_W-1:0]   pick_data;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   // Select the winner's address and data lanes.
   always_comb begin
      pick_addr = '0;
      pick_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == PTR_W'(i)) begin
            pick_addr = addr[i*ADDR_W +: ADDR_W];
            pick_data = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state logic. ack is only ever set for the ARB->WRITE transition,
   // so it is a single-cycle pulse and never high on consecutive cycles.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      addr_d  = addr_q;
      data_d  = data_q;
      ack_d   = '0;
      bank_we = 1'b0;
      unique case (state_q)
         ARB: begin
            if (|req) begin
               ack_d   = pick_grant;
               win_d   = pick_idx;
               addr_d  = pick_addr;
               data_d  = pick_data;
               state_d = WRITE;
            end
         end
         WRITE: begin
            bank_we = 1'b1;
            // Winner drops to lowest priority.
            ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
            state_d = ARB;
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB;
         ptr_q   <= PTR_W'(PTR_RESET);
         win_q   <= PTR_W'(STAGE_IDX_RESET);
         addr_q  <= ADDR_W'(STAGE_ADDR_RESET);
         data_q  <= DATA_W'(STAGE_DATA_RESET);
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
      end
   end

   // Reset takes priority, so a write staged when reset arrives is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            bank_q[r] <= '0;
         end
      end else if (bank_we) begin
         bank_q[addr_q] <= data_q;
      end
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_q
      assign q[r*DATA_W +: DATA_W] = bank_q[r];
   end

   assign ack  = ack_q;
   assign busy = (state_q == WRITE);

endmodule
